cmd_dispatch: RTL
=================

# cmd_dispatch

Parametrised UART command dispatcher: decodes a received opcode byte, grants exactly one of `N_CLIENTS` sub-blocks (sampler, sample reader, mem clear, trigger config, …) a one-hot activate, routes that client's transmit stream onto the shared UART transmitter, and returns to ready on the client's done. It sits between `uart_rx`/`uart_tx` and all command-handling sub-blocks. It replaces hand-written per-command state decode with a table-driven, N-wide version. It adds unknown-opcode NAK and a per-command watchdog.

## Interface
- `N_CLIENTS`, 8 — number of client slots (1..16).
- `OPCODES`, {8'h21,8'h22,8'h23,8'h24,8'h25,8'h31,8'h71,8'h72} — flattened `N_CLIENTS*8` opcode table; slot i uses bits [8i+7:8i].
- `NAK_BYTE`, 8'h3F — byte sent back on unknown opcode.
- `TIMEOUT_W`, 28 — watchdog counter width.
- `TIMEOUT_CYCLES`, 28'd150_000_000 — RUN cycles before forced abort (3 s at 50 MHz).

- `clk`  in  1  50 MHz system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from `uart_rx`.
- `rx_ready`  in  1  `uart_rx` byte-valid.
- `tx_active`  in  1  `uart_tx` busy.
- `client_done`  in  N_CLIENTS  per-client done.
- `client_tx_data`  in  N_CLIENTS*8  per-client tx byte, slot i at [8i+7:8i].
- `client_tx_start`  in  N_CLIENTS  per-client tx start.
- `client_activate`  out  N_CLIENTS  one-hot (or zero) grant.
- `tx_data`  out  8  muxed byte to `uart_tx`.
- `tx_start`  out  1  muxed start to `uart_tx`.
- `state_code`  out  8  display code for `seven_segment`.
- `busy`  out  1  high in RUN and NAK.
- `err_unknown`  out  1  one-cycle pulse on unmatched opcode.
- `err_timeout`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: READY, IDLE, RUN, NAK.
- READY: all activates 0, `tx_start` 0. When `rx_ready`=0 and `tx_active`=0, go to IDLE.
- IDLE: on `rx_ready`=1, compare `rx_data` against all slots.
  - Match: the lowest matching index wins. Latch `sel` and the opcode, then go to RUN.
  - No match: pulse `err_unknown`, go to NAK.
- RUN: `client_activate[sel]`=1. `tx_data`/`tx_start` follow slot `sel`.
  - On `client_done[sel]`=1, go to READY.
  - `client_done` of non-selected slots is ignored.
  - `rx_ready`/`rx_data` are not decoded in RUN; clients consume them directly.
- NAK: wait for `tx_active`=0, drive `tx_data`=`NAK_BYTE` with a single-cycle `tx_start`, then go to READY.
- `state_code`: IDLE 8'h00, READY 8'h01, RUN latched opcode, NAK 8'hEE.
- Reset values: every output is 0 and the state is READY.
  - Reset mid-RUN drops the activate immediately (asynchronously).
  - Entering READY rather than IDLE prevents a stale `rx_ready` from being decoded.
- Duplicate opcodes in the table are legal; the lowest slot shadows the higher ones.

## Timing
- `rx_ready` sampled in IDLE at cycle n: `client_activate[sel]` is high from cycle n+1.
- `client_done[sel]` sampled at cycle m: activate is low and `state_code`=8'h01 at m+1.
- RUN tx path is registered with one cycle latency.
  - `tx_start`(n+1) = `client_tx_start[sel]`(n) while in RUN.
  - `tx_data` follows the same rule and holds its last value otherwise.
  - `tx_start` is forced 0 outside RUN, except for the NAK single-cycle pulse.
- NAK start: at most one cycle after `tx_active` is seen low.
- Minimum turnaround between a done and the next decode: 2 cycles (READY then IDLE).

## Configuration
- `CMD_DISPATCH_TIMEOUT_EN` defined:
  - The watchdog counter clears on RUN entry and increments each RUN cycle.
  - When it reaches `TIMEOUT_CYCLES-1` without a done: pulse `err_timeout`, drop the activate, go to READY.
  - A done and a timeout in the same cycle: the done wins and no error is raised.
- Undefined: no counter; RUN waits indefinitely and `err_timeout` is tied to 0.

## Structure
- Package `cmd_dispatch_pkg` holds:
  - the state enum;
  - the `state_code` constants for IDLE/READY/NAK;
  - the default `NAK_BYTE`;
  - the default opcode table localparam.
- Sub-module `opcode_match`: combinational compare of `rx_data` against `OPCODES`, producing `hit` and the `$clog2(N_CLIENTS)`-bit lowest index.
- The state register, `sel`, the tx mux registers and the watchdog live in `cmd_dispatch`.

## Test plan
- Opcode 8'h22 with `rx_ready` pulse in IDLE -> `client_activate`=8'b0000_0010 next cycle and `state_code`=8'h22. `client_done[1]` -> activate 0 and `state_code`=8'h01 one cycle later.
- Opcode 8'h55 -> `err_unknown` pulse, `tx_data`=8'h3F with one-cycle `tx_start`, then READY -> IDLE.
- In RUN for slot 6, client pulses `tx_start` with data 8'hA5 -> `tx_start`/`tx_data`=8'hA5 one cycle later. `client_tx_start[0]` pulsing meanwhile -> no `tx_start`.
- `CMD_DISPATCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, client never done -> `err_timeout` and activate drop after 16 RUN cycles. A done on the 16th cycle -> no `err_timeout`.
- `reset` asserted mid-RUN while `rx_ready`=1 -> all outputs 0 immediately. After release, no decode until `rx_ready` has been seen 0.
- Opcode table {8'h21,8'h21,…} with 8'h21 received -> slot 0 granted, never slot 1.

Source files
------------

// File: rtl/cmd_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// cmd_dispatch_pkg
// Shared types and defaults for the UART command dispatcher.
//   - state_e          : dispatcher FSM states
//   - CODE_*           : state_code display values for IDLE/READY/NAK
//   - DEFAULT_*        : default client count, opcode table and NAK byte
//   - sel_width()      : width of a client index (never zero)
// -----------------------------------------------------------------------------
package cmd_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_NAK   = 2'd3
    } state_e;

    localparam logic [7:0] CODE_IDLE  = 8'h00;
    localparam logic [7:0] CODE_READY = 8'h01;
    localparam logic [7:0] CODE_NAK   = 8'hEE;

    localparam logic [7:0] DEFAULT_NAK_BYTE  = 8'h3F;
    localparam int         DEFAULT_N_CLIENTS = 8;

    // Slot 0 sits in the least significant byte: slot 0 = 8'h21 ... slot 7 = 8'h72.
    localparam logic [63:0] DEFAULT_OPCODES = 64'h7271_3125_2423_2221;

    // A single client still needs a one-bit index to keep ports legal.
    function automatic int sel_width(input int n);
        sel_width = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmd_dispatch_opcode_match.sv
// -----------------------------------------------------------------------------
// opcode_match
// Combinational lookup of a received byte in the flattened opcode table.
// Ports:
//   rx_data (in, 8)     : byte to look up
//   hit     (out, 1)    : at least one slot matches
//   idx     (out, SEL_W): lowest matching slot (0 when no hit)
// -----------------------------------------------------------------------------
module opcode_match
    import cmd_dispatch_pkg::*;
#(
    parameter int                     N_CLIENTS = DEFAULT_N_CLIENTS,
    parameter logic [N_CLIENTS*8-1:0] OPCODES   = DEFAULT_OPCODES,
    parameter int                     SEL_W     = sel_width(N_CLIENTS)
) (
    input  logic [7:0]       rx_data,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    logic match_s;

    // Scan from the top slot down so the lowest matching slot is written last.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        match_s = 1'b0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            match_s = (OPCODES[8*i +: 8] == rx_data);
            hit     = hit | match_s;
            idx     = match_s ? SEL_W'(i) : idx;
        end
    end

endmodule

// File: rtl/cmd_dispatch.sv
// -----------------------------------------------------------------------------
// cmd_dispatch
// Table-driven UART command dispatcher. Decodes an opcode byte, grants one
// client a one-hot activate, routes that client's transmit stream to the
// shared UART transmitter, and NAKs unknown opcodes.
// Optional feature: define CMD_DISPATCH_TIMEOUT_EN to enable the per-command
// watchdog (forced abort after TIMEOUT_CYCLES cycles in RUN).
// Ports:
//   clk, reset (async, active-low)
//   rx_data/rx_ready           : byte stream from uart_rx
//   tx_active                  : uart_tx busy
//   client_done/_tx_data/_tx_start : per-client inputs, slot i at bit/byte i
//   client_activate            : one-hot (or zero) grant
//   tx_data/tx_start           : registered byte/start to uart_tx
//   state_code                 : display code (IDLE 00, READY 01, RUN opcode, NAK EE)
//   busy, err_unknown, err_timeout : status and one-cycle error pulses
// -----------------------------------------------------------------------------
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int                     N_CLIENTS      = DEFAULT_N_CLIENTS,
    parameter logic [N_CLIENTS*8-1:0] OPCODES        = DEFAULT_OPCODES,
    parameter logic [7:0]             NAK_BYTE       = DEFAULT_NAK_BYTE,
    parameter int                     TIMEOUT_W      = 28,
    parameter logic [TIMEOUT_W-1:0]   TIMEOUT_CYCLES = TIMEOUT_W'(28'd150_000_000)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   tx_active,
    input  logic [N_CLIENTS-1:0]   client_done,
    input  logic [N_CLIENTS*8-1:0] client_tx_data,
    input  logic [N_CLIENTS-1:0]   client_tx_start,
    output logic [N_CLIENTS-1:0]   client_activate,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic [7:0]             state_code,
    output logic                   busy,
    output logic                   err_unknown,
    output logic                   err_timeout
);

    localparam int SEL_W = sel_width(N_CLIENTS);

    state_e               state_r;
    logic [SEL_W-1:0]     sel_r;
    logic [N_CLIENTS-1:0] activate_r;
    logic [7:0]           tx_data_r;
    logic                 tx_start_r;
    logic [7:0]           state_code_r;
    logic                 busy_r;
    logic                 err_unknown_r;

    logic                 hit_s;
    logic [SEL_W-1:0]     idx_s;
    logic                 sel_done_s;
    logic                 sel_tx_start_s;
    logic [7:0]           sel_tx_data_s;
    logic                 slot_s;

    function automatic logic [N_CLIENTS-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    opcode_match #(
        .N_CLIENTS (N_CLIENTS),
        .OPCODES   (OPCODES),
        .SEL_W     (SEL_W)
    ) u_match (
        .rx_data (rx_data),
        .hit     (hit_s),
        .idx     (idx_s)
    );

    // Pick the selected client's done/tx signals out of the packed buses.
    always_comb begin
        sel_done_s     = 1'b0;
        sel_tx_start_s = 1'b0;
        sel_tx_data_s  = 8'h00;
        slot_s         = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            slot_s         = (sel_r == SEL_W'(i));
            sel_done_s     = slot_s ? client_done[i]        : sel_done_s;
            sel_tx_start_s = slot_s ? client_tx_start[i]    : sel_tx_start_s;
            sel_tx_data_s  = slot_s ? client_tx_data[8*i +: 8] : sel_tx_data_s;
        end
    end

`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_r;
    logic                 err_timeout_r;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{1'b0, TIMEOUT_CYCLES};
`endif

    // Dispatcher FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_READY;
            sel_r         <= '0;
            activate_r    <= '0;
            tx_data_r     <= 8'h00;
            tx_start_r    <= 1'b0;
            state_code_r  <= 8'h00;
            busy_r        <= 1'b0;
            err_unknown_r <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            wd_r          <= '0;
            err_timeout_r <= 1'b0;
`endif
        end else begin
            err_unknown_r <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            err_timeout_r <= 1'b0;
`endif
            case (state_r)
                // READY only moves on once rx_ready is low, so a byte that
                // was still pending at done/reset is never decoded.
                ST_READY: begin
                    activate_r <= '0;
                    tx_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    if (!rx_ready && !tx_active) begin
                        state_r      <= ST_IDLE;
                        state_code_r <= CODE_IDLE;
                    end else begin
                        state_code_r <= CODE_READY;
                    end
                end
                ST_IDLE: begin
                    tx_start_r <= 1'b0;
                    if (rx_ready && hit_s) begin
                        sel_r        <= idx_s;
                        activate_r   <= onehot(idx_s);
                        state_code_r <= rx_data;
                        busy_r       <= 1'b1;
                        state_r      <= ST_RUN;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                        wd_r         <= '0;
`endif
                    end else if (rx_ready) begin
                        err_unknown_r <= 1'b1;
                        state_code_r  <= CODE_NAK;
                        busy_r        <= 1'b1;
                        state_r       <= ST_NAK;
                    end else begin
                        state_code_r <= CODE_IDLE;
                    end
                end
                ST_RUN: begin
                    tx_start_r <= sel_tx_start_s;
                    tx_data_r  <= sel_tx_data_s;
                    if (sel_done_s) begin
                        activate_r   <= '0;
                        busy_r       <= 1'b0;
                        state_code_r <= CODE_READY;
                        state_r      <= ST_READY;
                    end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                    else if (wd_r == TIMEOUT_CYCLES - TIMEOUT_W'(1)) begin
                        err_timeout_r <= 1'b1;
                        activate_r    <= '0;
                        busy_r        <= 1'b0;
                        state_code_r  <= CODE_READY;
                        state_r       <= ST_READY;
                    end
`endif
                    else begin
`ifdef CMD_DISPATCH_TIMEOUT_EN
                        wd_r <= wd_r + TIMEOUT_W'(1);
`endif
                        state_r <= ST_RUN;
                    end
                end
                ST_NAK: begin
                    if (!tx_active) begin
                        tx_start_r   <= 1'b1;
                        tx_data_r    <= NAK_BYTE;
                        busy_r       <= 1'b0;
                        state_code_r <= CODE_READY;
                        state_r      <= ST_READY;
                    end else begin
                        tx_start_r <= 1'b0;
                    end
                end
                default: begin
                    activate_r   <= '0;
                    tx_start_r   <= 1'b0;
                    busy_r       <= 1'b0;
                    state_code_r <= CODE_READY;
                    state_r      <= ST_READY;
                end
            endcase
        end
    end

    assign client_activate = activate_r;
    assign tx_data         = tx_data_r;
    assign tx_start        = tx_start_r;
    assign state_code      = state_code_r;
    assign busy            = busy_r;
    assign err_unknown     = err_unknown_r;
`ifdef CMD_DISPATCH_TIMEOUT_EN
    assign err_timeout     = err_timeout_r;
`else
    assign err_timeout     = 1'b0;
`endif

endmodule
